pwm_multichannel: RTL

//  N-channel PWM generator with a shared time base. Successor to the single 8-bit motor PWM.

---
 rtl/pwm_multichannel_if.sv | 44 ++++
 rtl/pwm_multichannel.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pwm_multichannel_if.sv
// Control and output bundle of the multichannel PWM.
// PWM_COMPLEMENT_EN adds dead time and complementary outputs.
interface pwm_multichannel_if #(
  parameter int CH    = 4,
  parameter int W     = 8,
  parameter int PRE_W = 8
`ifdef PWM_COMPLEMENT_EN
  , parameter int DT_W = 4
`endif
);
  logic             iEnable;
  logic             iMode;
  logic [PRE_W-1:0] iPrescale;
  logic [W-1:0]     iPeriod;
  logic [CH*W-1:0]  iDuty;
  logic [CH-1:0]    oPWM;
  logic             oPeriodTick;
`ifdef PWM_COMPLEMENT_EN
  logic [DT_W-1:0]  iDeadTime;
  logic [CH-1:0]    oPWMn;

  modport master (
    output iEnable, iMode, iPrescale,
    output iPeriod, iDuty, iDeadTime,
    input  oPWM, oPeriodTick, oPWMn
  );
  modport slave (
    input  iEnable, iMode, iPrescale,
    input  iPeriod, iDuty, iDeadTime,
    output oPWM, oPeriodTick, oPWMn
  );
`else
  modport master (
    output iEnable, iMode, iPrescale,
    output iPeriod, iDuty,
    input  oPWM, oPeriodTick
  );
  modport slave (
    input  iEnable, iMode, iPrescale,
    input  iPeriod, iDuty,
    output oPWM, oPeriodTick
  );
`endif
endinterface

// File: rtl/pwm_multichannel.sv
// N-channel PWM, shared prescaled time base, edge/center modes.
// Optional PWM_COMPLEMENT_EN: dead-time complementary outputs.
module pwm_multichannel #(
  parameter int CH    = 4,
  parameter int W     = 8,
  parameter int PRE_W = 8
`ifdef PWM_COMPLEMENT_EN
  , parameter int DT_W = 4
`endif
) (
  input logic               iCLK,
  input logic               inReset,
  pwm_multichannel_if.slave bus
);

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_e;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [W-1:0]     cnt_q, cnt_d;
  logic [W-1:0]     per_q, per_d;
  logic [CH*W-1:0]  duty_q, duty_d;
  logic             mode_q, mode_d;
  dir_e             dir_q, dir_d;
  logic [CH-1:0]    pwm_q, pwm_d;
  logic             tick_q, tick_d;
  logic             ptick;
  logic             bnd;

  // time base step, boundary detect and shadow load
  always_comb begin
    pre_d  = pre_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    per_d  = per_q;
    duty_d = duty_q;
    mode_d = mode_q;
    bnd    = 1'b0;
    ptick  = (pre_q >= bus.iPrescale);
    if (!bus.iEnable) begin
      pre_d = '0;
      cnt_d = '0;
      dir_d = UP;
    end else if (ptick) begin
      pre_d = '0;
      if (!mode_q) begin
        bnd   = (cnt_q >= per_q);
        cnt_d = bnd ? '0 : cnt_q + 1'b1;
        dir_d = UP;
      end else if (per_q == '0) begin
        bnd   = 1'b1;
        cnt_d = '0;
        dir_d = UP;
      end else begin
        unique case (dir_q)
          UP: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d >= per_q) dir_d = DOWN;
          end
          DOWN: begin
            bnd   = (cnt_q <= W'(1));
            cnt_d = bnd ? '0 : cnt_q - 1'b1;
            dir_d = bnd ? UP : DOWN;
          end
        endcase
      end
    end else begin
      pre_d = pre_q + 1'b1;
    end
    if (!bus.iEnable || bnd) begin
      per_d  = bus.iPeriod;
      duty_d = bus.iDuty;
      mode_d = bus.iMode;
    end
    tick_d = bnd;
  end

  // per-channel compare against the current shadow duty
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < CH; i++) begin
      pwm_d[i] = bus.iEnable &
                 (cnt_q < duty_q[i*W +: W]);
    end
  end

  // state and output registers
  always_ff @(posedge iCLK or negedge inReset) begin
    if (!inReset) begin
      pre_q  <= '0;
      cnt_q  <= '0;
      dir_q  <= UP;
      per_q  <= '0;
      duty_q <= '0;
      mode_q <= 1'b0;
      pwm_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      per_q  <= per_d;
      duty_q <= duty_d;
      mode_q <= mode_d;
      pwm_q  <= pwm_d;
      tick_q <= tick_d;
    end
  end

  assign bus.oPeriodTick = tick_q;

`ifdef PWM_COMPLEMENT_EN
  logic [DT_W-1:0] dcnt_q [CH];
  logic [DT_W-1:0] dcnt_d [CH];
  logic            en_q;
  logic [CH-1:0]   ok;

  // dead counters restart on every raw edge and while idle
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      dcnt_d[i] = dcnt_q[i];
      if (!bus.iEnable || (pwm_d[i] != pwm_q[i]))
        dcnt_d[i] = '0;
      else if (dcnt_q[i] != '1)
        dcnt_d[i] = dcnt_q[i] + 1'b1;
    end
  end

  // dead counter and enable registers
  always_ff @(posedge iCLK or negedge inReset) begin
    if (!inReset) begin
      en_q <= 1'b0;
      for (int i = 0; i < CH; i++) dcnt_q[i] <= '0;
    end else begin
      en_q <= bus.iEnable;
      for (int i = 0; i < CH; i++) dcnt_q[i] <= dcnt_d[i];
    end
  end

  // a level must outlast the dead time to reach a pin
  always_comb begin
    ok = '0;
    for (int i = 0; i < CH; i++)
      ok[i] = (dcnt_q[i] >= bus.iDeadTime);
  end

  assign bus.oPWM  = pwm_q & ok;
  assign bus.oPWMn = {CH{en_q}} & ~pwm_q & ok;
`else
  assign bus.oPWM = pwm_q;
`endif

endmodule
